// File: rtl/tl_road_model.sv
// tl_road_model -- vehicle-side end of the traffic-light interface.
//
// Each street keeps a queue of waiting cars. A car joins on an arrival pulse.
// While its light is green (code 00), the car at the head of the queue leaves
// after PASS_CYCLES consecutive green cycles. The block also watches the two
// light codes and flags combinations that should never occur.
//
// Parameters:
//   Q_W          queue counter width; the queue saturates at 2**Q_W-1
//   PASS_CYCLES  green cycles one car needs to clear the stop line (>=1)
//
// Ports:
//   clk, reset   rising-edge clock, synchronous active-high reset
//   La, Lb       light codes: 00 green, 01 yellow, 10 red, 11 illegal
//   arr_a/arr_b  one car arrives on that street this cycle
//   Ta, Tb       sensor: queue non-empty (registered)
//   q_a, q_b     current queue length
//   dep_a/dep_b  one-cycle pulse: a car left that street
//   ovf_a/ovf_b  sticky: an arrival was dropped because the queue was full
//   err          sticky: code 11 on either light, or both lights green
//   tot_a/tot_b  16-bit wrapping departure counters, only when the
//                TL_ROAD_STATS_EN macro is defined
//
// Handshake note: there is no backpressure anywhere. Arrivals and light codes
// are sampled on every rising edge, and every output is a registered value
// that is valid for the whole cycle after the edge that produced it.
`timescale 1ns/1ps

module tl_road_street #(
  parameter int Q_W         = 4,
  parameter int PASS_CYCLES = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [1:0]     light,
  input  logic           arr,
  output logic           t,
  output logic [Q_W-1:0] q,
  output logic           dep,
  output logic           ovf
);
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, PASS = 2'd2} state_t;

  localparam int             TW     = $clog2(PASS_CYCLES) + 1;
  localparam logic [TW-1:0]  T_LAST = TW'(PASS_CYCLES - 1);
  localparam logic [TW-1:0]  T_ONE  = TW'(1);
  localparam logic [Q_W-1:0] Q_MAX  = '1;
  localparam logic [Q_W-1:0] Q_ONE  = Q_W'(1);

  state_t        state;
  logic [TW-1:0] timer;
  logic          green;
  logic          pass_now;
  logic          leave;
  logic          full_drop;
  logic [Q_W-1:0] q_next;

  // The state register is IDLE exactly when the queue is empty, so a car is
  // being served whenever the state is non-IDLE and the light is green. Codes
  // 01, 10 and 11 all count as "not green" and stop the car.
  always_comb begin
    green     = (light == 2'b00);
    pass_now  = (state != IDLE) && green;
    leave     = pass_now && (timer == T_LAST);
    full_drop = arr && !leave && (q == Q_MAX);
    q_next    = q;
    if (arr && !leave && (q != Q_MAX))
      q_next = q + Q_ONE;
    else if (!arr && leave)
      q_next = q - Q_ONE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      timer <= '0;
      q     <= '0;
      t     <= 1'b0;
      dep   <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      q   <= q_next;
      t   <= (q_next != '0);
      dep <= leave;
      if (full_drop)
        ovf <= 1'b1;
      // Any non-green cycle throws away the partial pass of the head car.
      if (pass_now && !leave)
        timer <= timer + T_ONE;
      else
        timer <= '0;
      if (q_next == '0)
        state <= IDLE;
      else if (green)
        state <= PASS;
      else
        state <= WAIT;
    end
  end
endmodule

module tl_road_model #(
  parameter int Q_W         = 4,
  parameter int PASS_CYCLES = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [1:0]     La,
  input  logic [1:0]     Lb,
  input  logic           arr_a,
  input  logic           arr_b,
  output logic           Ta,
  output logic           Tb,
  output logic [Q_W-1:0] q_a,
  output logic [Q_W-1:0] q_b,
  output logic           dep_a,
  output logic           dep_b,
  output logic           ovf_a,
  output logic           ovf_b,
  output logic           err
`ifdef TL_ROAD_STATS_EN
  ,
  output logic [15:0]    tot_a,
  output logic [15:0]    tot_b
`endif
);
  tl_road_street #(.Q_W(Q_W), .PASS_CYCLES(PASS_CYCLES)) u_street_a (
    .clk   (clk),
    .reset (reset),
    .light (La),
    .arr   (arr_a),
    .t     (Ta),
    .q     (q_a),
    .dep   (dep_a),
    .ovf   (ovf_a)
  );

  tl_road_street #(.Q_W(Q_W), .PASS_CYCLES(PASS_CYCLES)) u_street_b (
    .clk   (clk),
    .reset (reset),
    .light (Lb),
    .arr   (arr_b),
    .t     (Tb),
    .q     (q_b),
    .dep   (dep_b),
    .ovf   (ovf_b)
  );

  // Both queues keep draining when both lights are green; only the flag is
  // raised.
  always_ff @(posedge clk) begin
    if (reset)
      err <= 1'b0;
    else if ((La == 2'b11) || (Lb == 2'b11) || ((La == 2'b00) && (Lb == 2'b00)))
      err <= 1'b1;
  end

`ifdef TL_ROAD_STATS_EN
  // Counts the registered departure pulses, so a total moves one cycle after
  // the dep pulse it records.
  always_ff @(posedge clk) begin
    if (reset) begin
      tot_a <= '0;
      tot_b <= '0;
    end else begin
      tot_a <= tot_a + 16'(dep_a);
      tot_b <= tot_b + 16'(dep_b);
    end
  end
`endif
endmodule

// File: tb/tb_tl_road_model.sv
// Testbench for tl_road_model (Q_W=4, PASS_CYCLES=2).
// Directed vectors with hand-computed expectations, and a queue-level
// reference model that is compared against the DUT on every falling edge.
`timescale 1ns/1ps

module tb_tl_road_model;
  localparam int Q_W         = 4;
  localparam int PASS_CYCLES = 2;
  localparam int QMAX        = (1 << Q_W) - 1;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]     La = 2'b10, Lb = 2'b00;
  logic           arr_a = 1'b0, arr_b = 1'b0;
  logic           Ta, Tb, dep_a, dep_b, ovf_a, ovf_b, err;
  logic [Q_W-1:0] q_a, q_b;
`ifdef TL_ROAD_STATS_EN
  logic [15:0]    tot_a, tot_b;
`endif

  tl_road_model #(.Q_W(Q_W), .PASS_CYCLES(PASS_CYCLES)) dut (
    .clk   (clk),
    .reset (reset),
    .La    (La),
    .Lb    (Lb),
    .arr_a (arr_a),
    .arr_b (arr_b),
    .Ta    (Ta),
    .Tb    (Tb),
    .q_a   (q_a),
    .q_b   (q_b),
    .dep_a (dep_a),
    .dep_b (dep_b),
    .ovf_a (ovf_a),
    .ovf_b (ovf_b),
    .err   (err)
`ifdef TL_ROAD_STATS_EN
    ,
    .tot_a (tot_a),
    .tot_b (tot_b)
`endif
  );

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: per street a car count and the number of green cycles
  // the head car has been served so far.
  int mq[2];
  int prog[2];
  bit mdep[2];
  bit movf[2];
  bit merr;
  int mtot[2];

  always @(posedge clk) begin : model
    int lt;
    bit ar, lv;
    if (reset) begin
      for (int s = 0; s < 2; s++) begin
        mq[s] = 0; prog[s] = 0; mdep[s] = 0; movf[s] = 0; mtot[s] = 0;
      end
      merr = 0;
    end else begin
      for (int s = 0; s < 2; s++) begin
        lt = (s == 0) ? int'(La) : int'(Lb);
        ar = (s == 0) ? arr_a : arr_b;
        mtot[s] = (mtot[s] + (mdep[s] ? 1 : 0)) & 16'hFFFF;
        lv = 0;
        if (mq[s] > 0 && lt == 0) begin
          prog[s]++;
          if (prog[s] == PASS_CYCLES) begin
            lv = 1;
            prog[s] = 0;
          end
        end else begin
          prog[s] = 0;
        end
        mdep[s] = lv;
        if (ar && !lv) begin
          if (mq[s] == QMAX) movf[s] = 1;
          else mq[s]++;
        end else if (lv && !ar) begin
          mq[s]--;
        end
      end
      if (La == 2'b11 || Lb == 2'b11 || (La == 2'b00 && Lb == 2'b00))
        merr = 1;
    end
  end

  // Scoreboard compare on every falling edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("q_a", 32'(q_a), 32'(mq[0]));
      check("q_b", 32'(q_b), 32'(mq[1]));
      check("Ta", 32'(Ta), 32'(mq[0] != 0));
      check("Tb", 32'(Tb), 32'(mq[1] != 0));
      check("dep_a", 32'(dep_a), 32'(mdep[0]));
      check("dep_b", 32'(dep_b), 32'(mdep[1]));
      check("ovf_a", 32'(ovf_a), 32'(movf[0]));
      check("ovf_b", 32'(ovf_b), 32'(movf[1]));
      check("err", 32'(err), 32'(merr));
`ifdef TL_ROAD_STATS_EN
      check("tot_a", 32'(tot_a), 32'(mtot[0]));
      check("tot_b", 32'(tot_b), 32'(mtot[1]));
`endif
    end
  end

  // driver: apply inputs, let one rising edge pass, settle 1ns
  task automatic tick(input logic [1:0] la, input logic [1:0] lb, input logic aa, input logic ab);
    La = la; Lb = lb; arr_a = aa; arr_b = ab;
    @(posedge clk);
    #1;
  endtask

  int exp_q2[6] = '{3, 2, 2, 1, 1, 0};
  int exp_d2[6] = '{0, 1, 0, 1, 0, 1};
  int exp_qb[7] = '{1, 2, 2, 2, 1, 1, 0};
  int exp_db[7] = '{0, 0, 1, 0, 1, 0, 1};

  initial begin
    // reset
    reset = 1'b1;
    tick(2'b10, 2'b00, 0, 0);
    tick(2'b10, 2'b00, 0, 0);
    cmp_en = 1'b1;
    reset = 1'b0;
    check("rst q_a", 32'(q_a), 0);
    check("rst Ta", 32'(Ta), 0);
    check("rst err", 32'(err), 0);

    // 1: three arrivals on red
    for (int i = 0; i < 3; i++) begin
      tick(2'b10, 2'b00, 1, 0);
      check("t1 q_a", 32'(q_a), 32'(i + 1));
      check("t1 Ta", 32'(Ta), 1);
      check("t1 dep_a", 32'(dep_a), 0);
    end

    // 2: green on A drains one car every 2 cycles
    for (int i = 0; i < 6; i++) begin
      tick(2'b00, 2'b10, 0, 0);
      check("t2 q_a", 32'(q_a), 32'(exp_q2[i]));
      check("t2 dep_a", 32'(dep_a), 32'(exp_d2[i]));
      check("t2 Tb", 32'(Tb), 0);
    end
    check("t2 Ta", 32'(Ta), 0);
    tick(2'b00, 2'b10, 0, 0);
`ifdef TL_ROAD_STATS_EN
    check("t2 tot_a", 32'(tot_a), 3);
`endif

    // 3: one green cycle then yellow loses the partial pass
    tick(2'b10, 2'b10, 1, 0);
    tick(2'b10, 2'b10, 1, 0);
    tick(2'b00, 2'b10, 0, 0);
    check("t3 dep_a g", 32'(dep_a), 0);
    tick(2'b01, 2'b10, 0, 0);
    check("t3 dep_a y", 32'(dep_a), 0);
    tick(2'b00, 2'b10, 0, 0);
    check("t3 dep_a g2", 32'(dep_a), 0);
    check("t3 q_a", 32'(q_a), 2);
    tick(2'b10, 2'b10, 0, 0);

    // 4: fill to 15, overflow, then arrival on the departure edge
    for (int i = 0; i < 13; i++) tick(2'b10, 2'b10, 1, 0);
    check("t4 q_a full", 32'(q_a), 15);
    check("t4 ovf_a pre", 32'(ovf_a), 0);
    tick(2'b10, 2'b10, 1, 0);
    check("t4 q_a hold", 32'(q_a), 15);
    check("t4 ovf_a", 32'(ovf_a), 1);
    tick(2'b00, 2'b10, 1, 0);
    check("t4 q_a g1", 32'(q_a), 15);
    tick(2'b00, 2'b10, 1, 0);
    check("t4 q_a dep", 32'(q_a), 15);
    check("t4 dep_a", 32'(dep_a), 1);

    // drain to 5 with Lb=11 raising err, then stop mid-pass and reset
    for (int i = 0; i < 20; i++) tick(2'b00, 2'b11, 0, 0);
    check("t6 q_a", 32'(q_a), 5);
    check("t6 err", 32'(err), 1);
    tick(2'b00, 2'b10, 0, 0);
    reset = 1'b1;
    tick(2'b00, 2'b10, 0, 0);
    reset = 1'b0;
    check("t6 q_a rst", 32'(q_a), 0);
    check("t6 Ta rst", 32'(Ta), 0);
    check("t6 dep_a rst", 32'(dep_a), 0);
    check("t6 ovf_a rst", 32'(ovf_a), 0);
    check("t6 err rst", 32'(err), 0);

    // street B: arrivals while green, including arrival on a departure edge
    for (int i = 0; i < 7; i++) begin
      tick(2'b10, 2'b00, 0, (i < 3) ? 1'b1 : 1'b0);
      check("b q_b", 32'(q_b), 32'(exp_qb[i]));
      check("b dep_b", 32'(dep_b), 32'(exp_db[i]));
    end
    check("b Tb", 32'(Tb), 0);
    check("b err", 32'(err), 0);

    // 5: both green, then code 11
    tick(2'b00, 2'b00, 0, 0);
    check("t5 err both", 32'(err), 1);
    tick(2'b10, 2'b10, 0, 0);
    check("t5 err sticky", 32'(err), 1);
    reset = 1'b1;
    tick(2'b10, 2'b10, 0, 0);
    reset = 1'b0;
    check("t5 err rst", 32'(err), 0);
    tick(2'b11, 2'b10, 0, 0);
    check("t5 err 11", 32'(err), 1);
    tick(2'b10, 2'b10, 0, 0);
    tick(2'b10, 2'b10, 0, 0);

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
